// File: rtl/fc_argmax_rx_if.sv
// Score-stream and result-handshake bundle between the FC layer, the
// argmax receiver and the host readout.
// Ports: frame_n/score_in/result_ack toward the receiver; result_valid,
//        class_idx, max_score, margin, short_frame back to the host.
interface fc_argmax_rx_if #(
    parameter int IDX_W = 4
);
    logic                    frame_n;
    logic signed [19:0]      score_in;
    logic                    result_ack;
    logic                    result_valid;
    logic [IDX_W-1:0]        class_idx;
    logic signed [19:0]      max_score;
    logic signed [20:0]      margin;
    logic                    short_frame;

    modport master (
        output frame_n,
        output score_in,
        output result_ack,
        input  result_valid,
        input  class_idx,
        input  max_score,
        input  margin,
        input  short_frame
    );

    modport slave (
        input  frame_n,
        input  score_in,
        input  result_ack,
        output result_valid,
        output class_idx,
        output max_score,
        output margin,
        output short_frame
    );
endinterface

// File: rtl/fc_argmax_rx.sv
// Argmax receiver for the FC layer's serial score stream.
// Ports: clk_in, rst_n (sync, active-low), bus (slave side of
//        fc_argmax_rx_if: frame/score in, valid/ack result out).
module fc_argmax_rx #(
    parameter int NUM_OUT = 10,
    parameter int LAG     = 1,
    parameter int IDX_W   = 4
) (
    input logic            clk_in,
    input logic            rst_n,
    fc_argmax_rx_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        COLLECT,
        WAIT_ACK,
        REARM
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OUT - 1);
    localparam logic signed [19:0] SCORE_MIN = 20'sh80000;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         lag_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic signed [19:0] max_q;
    logic signed [19:0] sec_q;
    logic               short_q;
    logic               last_lag;
    logic               first;

    // For LAG=0 the compare never matches, but SKIP is unreachable then.
    assign last_lag = ({30'd0, lag_q} == 32'(LAG - 1));
    assign first    = (cnt_q == '0);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.frame_n) begin
                    state_d = (LAG == 0) ? COLLECT : SKIP;
                end
            end
            SKIP: begin
                if (bus.frame_n) begin
                    state_d = WAIT_ACK;
                end else if (last_lag) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.frame_n || cnt_q == LAST) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.result_ack) begin
                    state_d = bus.frame_n ? IDLE : REARM;
                end
            end
            REARM: begin
                if (bus.frame_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            lag_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            sec_q   <= '0;
            short_q <= 1'b0;
        end else begin
            if (state_q != COLLECT && state_d == COLLECT) begin
                short_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    lag_q <= '0;
                    cnt_q <= '0;
                end
                SKIP: begin
                    lag_q <= lag_q + 2'd1;
                    if (bus.frame_n) begin
                        short_q <= 1'b1;
                        idx_q   <= '0;
                        max_q   <= '0;
                        sec_q   <= '0;
                    end
                end
                COLLECT: begin
                    if (bus.frame_n) begin
                        // Aborted frame: the sample in this cycle is dropped.
                        short_q <= 1'b1;
                        if (first) begin
                            idx_q <= '0;
                            max_q <= '0;
                            sec_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (first) begin
                            max_q <= bus.score_in;
                            idx_q <= '0;
                            sec_q <= SCORE_MIN;
                        end else if (bus.score_in > max_q) begin
                            sec_q <= max_q;
                            max_q <= bus.score_in;
                            idx_q <= cnt_q;
                        end else if (bus.score_in > sec_q) begin
                            sec_q <= bus.score_in;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_valid = (state_q == WAIT_ACK);
    assign bus.class_idx    = idx_q;
    assign bus.max_score    = max_q;
    assign bus.margin       = {max_q[19], max_q} - {sec_q[19], sec_q};
    assign bus.short_frame  = short_q;
endmodule

// File: tb/tb_fc_argmax_rx.sv
// Directed bench for fc_argmax_rx: nominal, ties, held flag, short
// frames, handshake hold and mid-frame reset.
module tb_fc_argmax_rx;
    localparam int NUM_OUT = 10;
    localparam int LAG     = 1;
    localparam int IDX_W   = 4;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    fc_argmax_rx_if #(.IDX_W(IDX_W)) bus ();

    fc_argmax_rx #(
        .NUM_OUT(NUM_OUT),
        .LAG    (LAG),
        .IDX_W  (IDX_W)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int early;
    int bad;
    int sc[16];

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives one frame from IDLE; n scores, then raises frame_n
    // unless hold is set (in which case 999s follow the frame).
    task automatic feed(input int n, input bit hold);
        cyc   = 0;
        early = 0;
        for (int k = 0; k < LAG + 1 + n; k++) begin
            if (bus.result_valid) early++;
            bus.frame_n = 1'b0;
            if (k >= LAG + 1) bus.score_in = 20'(sc[k-LAG-1]);
            else              bus.score_in = 20'sd0;
            @(negedge clk_in);
            cyc++;
        end
        bus.score_in = 20'sd999;
        if (!hold) bus.frame_n = 1'b1;
    endtask

    task automatic wait_valid();
        while (!bus.result_valid && cyc < 64) begin
            @(negedge clk_in);
            cyc++;
        end
        check("valid", bus.result_valid, 1);
    endtask

    task automatic ack(input bit fr);
        bus.result_ack = 1'b1;
        bus.frame_n    = fr;
        @(negedge clk_in);
        bus.result_ack = 1'b0;
        check("ack_drop", bus.result_valid, 0);
    endtask

    task automatic fields(input string tag, input int idx, input int mx,
                          input int mg, input int sh);
        check({tag, "_idx"}, bus.class_idx, idx);
        check({tag, "_max"}, bus.max_score, mx);
        check({tag, "_margin"}, bus.margin, mg);
        check({tag, "_short"}, bus.short_frame, sh);
    endtask

    task automatic set_nominal();
        sc = '{1998, 357, 671, -899, -2305, 209, 2178, -862, 826, -2172,
               0, 0, 0, 0, 0, 0};
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.frame_n    = 1'b1;
        bus.score_in   = 20'sd0;
        bus.result_ack = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_valid", bus.result_valid, 0);
        fields("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Nominal frame plus latency
        set_nominal();
        feed(NUM_OUT, 1'b0);
        check("nom_early", early, 0);
        wait_valid();
        check("nom_latency", cyc, LAG + NUM_OUT + 1);
        fields("nom", 6, 2178, 180, 0);

        // Result held stable without ack
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (!bus.result_valid || bus.class_idx != 6 ||
                bus.max_score != 2178 || bus.margin != 180)
                bad++;
        end
        check("hold_stable", bad, 0);
        ack(1'b1);

        // All equal negatives
        for (int i = 0; i < 16; i++) sc[i] = -500;
        feed(NUM_OUT, 1'b0);
        wait_valid();
        fields("tie", 0, -500, 0, 0);
        ack(1'b1);

        // Tie on second place, lowest index wins
        for (int i = 0; i < 16; i++) sc[i] = -9;
        sc[0] = -7; sc[1] = -3; sc[2] = -3;
        feed(NUM_OUT, 1'b0);
        wait_valid();
        fields("tie2", 1, -3, 0, 0);
        ack(1'b1);

        // Frame flag held low with trailing 999s
        set_nominal();
        feed(NUM_OUT, 1'b1);
        wait_valid();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (!bus.result_valid || bus.class_idx != 6 ||
                bus.max_score != 2178 || bus.margin != 180)
                bad++;
        end
        check("held_ignore", bad, 0);
        ack(1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (bus.result_valid) bad++;
        end
        check("rearm_quiet", bad, 0);
        bus.frame_n = 1'b1;
        @(negedge clk_in);
        for (int i = 0; i < 16; i++) sc[i] = -500;
        feed(NUM_OUT, 1'b0);
        wait_valid();
        fields("rearm_next", 0, -500, 0, 0);
        ack(1'b1);

        // Single sample then abort
        sc[0] = 100;
        feed(1, 1'b0);
        wait_valid();
        fields("one", 0, 100, 100 + 524288, 1);
        ack(1'b1);

        // Short frame after four samples
        sc[0] = 10; sc[1] = 50; sc[2] = 20; sc[3] = 5;
        feed(4, 1'b0);
        wait_valid();
        fields("short", 1, 50, 30, 1);
        ack(1'b1);

        // Abort during SKIP
        bus.frame_n = 1'b0;
        @(negedge clk_in);
        bus.frame_n = 1'b1;
        @(negedge clk_in);
        check("skip_valid", bus.result_valid, 1);
        fields("skip", 0, 0, 0, 1);
        ack(1'b1);

        // Reset mid-collect
        set_nominal();
        feed(5, 1'b1);
        rst_n       = 1'b0;
        bus.frame_n = 1'b1;
        @(negedge clk_in);
        check("mrst_valid", bus.result_valid, 0);
        fields("mrst", 0, 0, 0, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (bus.result_valid) bad++;
        end
        check("mrst_quiet", bad, 0);
        feed(NUM_OUT, 1'b0);
        wait_valid();
        check("post_latency", cyc, LAG + NUM_OUT + 1);
        fields("post", 6, 2178, 180, 0);
        ack(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fc_argmax_rx.md
Name: fc_argmax_rx

Overview:
- Receiving end of the fully-connected layer's serial score stream.
- Consumes the NUM_OUT signed 20-bit class scores the FC layer emits while its active-low frame flag is low.
- Tracks running maximum, runner-up and winning index; presents the classification result through a valid/ack handshake to the host/readout logic.
- Sits between the last FC layer and the result register/UART readout.

Parameters:
NUM_OUT, 10, scores per frame (class count); 2..16.
LAG, 1, cycles between frame_n falling and first valid score (FC output register delay); 0..3.
IDX_W, 4, width of class index; must satisfy 2^IDX_W >= NUM_OUT.

Ports:
clk_in  in  1  clock, all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
frame_n  in  1  active-low frame flag from FC layer; low for the frame, may stay low indefinitely after the last score.
score_in  in  20  signed score, one per cycle, starting LAG cycles after frame_n falls.
result_ack  in  1  host acknowledge; consumed only while result_valid=1.
result_valid  out  1  result fields stable and valid.
class_idx  out  IDX_W  index of maximum score.
max_score  out  20  signed maximum score.
margin  out  21  max_score minus runner-up, signed, always >= 0.
short_frame  out  1  frame_n rose before NUM_OUT scores were captured.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - All outputs 0; FSM to IDLE; counters cleared.
  - Reset mid-frame discards partial results; no result_valid is produced for that frame.
- FSM states: IDLE, SKIP, COLLECT, WAIT_ACK, REARM.
- IDLE:
  - frame_n=0 → SKIP with lag counter=0, or straight to COLLECT if LAG=0.
  - frame_n=1 → stay.
- SKIP:
  - Counts LAG cycles, then → COLLECT.
  - frame_n=1 inside SKIP → WAIT_ACK with short_frame=1, class_idx=0, max_score=0, margin=0.
- COLLECT:
  - Samples score_in every cycle; sample counter cnt runs 0..NUM_OUT-1.
  - cnt==0: max<=s, idx<=0, second<=-2^19.
  - cnt>0, s>max (strict): second<=max, max<=s, idx<=cnt. Ties keep the lowest index.
  - cnt>0, otherwise: if s>second, second<=s.
  - After sample cnt==NUM_OUT-1 → WAIT_ACK.
  - Scores arriving after that sample are ignored.
  - frame_n=1 during COLLECT before the last sample: the sample in that cycle is NOT taken; → WAIT_ACK with short_frame=1 and fields from the samples already taken.
- Result timing:
  - result_valid rises the cycle after the last sample is captured.
  - Latency from frame_n falling to result_valid = LAG+NUM_OUT+1 cycles (12 at defaults).
  - margin = max - second computed in 21 bits. If only one sample was taken, margin = max + 2^19.
- WAIT_ACK:
  - result_valid=1; all result fields held constant.
  - result_ack=1 → result_valid<=0 next cycle; → IDLE if frame_n=1 in that cycle, else → REARM.
  - Result fields keep their last values after the ack until the next frame's first sample.
  - short_frame clears when the next frame enters COLLECT.
- REARM:
  - Waits for frame_n=1, then → IDLE.
  - Prevents a held-low frame flag from retriggering collection.
- Frame-flag edge cases:
  - frame_n toggling while in WAIT_ACK or REARM is ignored except as stated above.
  - A new frame starting before the ack is lost; the FC layer guarantees frames are spaced by more than the host ack time.
- Arithmetic:
  - All compares are signed 20-bit; no saturation is needed.
  - margin uses sign-extended 21-bit subtraction.

Test Plan:
- Nominal frame: frame_n low, LAG=1, scores {1998,357,671,-899,-2305,209,2178,-862,826,-2172} → result_valid at cycle 12; class_idx=6, max_score=2178, margin=180, short_frame=0.
- Ties and negatives: scores all -500 → class_idx=0, max_score=-500, margin=0. Then {-7,-3,-3,-9,...(-9)} → class_idx=1, margin=0.
- Held frame flag: frame_n stays low 40 cycles past the last score with score_in=999 after the 10th sample → result unchanged (the 999s are ignored). Ack while frame_n low → REARM, no second result until frame_n goes high then low.
- Short frame: frame_n rises after 4 samples {10,50,20,5} → short_frame=1, class_idx=1, max_score=50, margin=30. Rising during SKIP → all fields 0, short_frame=1.
- Handshake: hold result_ack=0 for 100 cycles → fields stable and result_valid=1 throughout. Pulse ack with frame_n=1 → result_valid=0 next cycle, FSM in IDLE, and the next frame is accepted.
- Reset mid-COLLECT after 5 samples → all outputs 0 the next cycle, no result_valid. A following full frame yields the correct result.
